// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide functional unit: opcodes,
// latency-counter width, FSM state type and a small opcode helper.
package muldiv_pkg;

  // Opcodes the unit executes; every other 3-bit value is illegal.
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Width of the latency down-counter; it covers latencies 1..15.
  localparam int CNT_W = 4;

  // Unit-level control states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_CDB = 2'd2
  } state_t;

  // True for the two opcodes this unit knows how to execute.
  function automatic logic is_legal_op(input logic [2:0] code);
    return (code == OP_MUL) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter used to time the execute phase of an operation.
// It stops at zero instead of wrapping, and reports when it is at zero.
module lat_counter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Count register: reset clears, load wins over decrement, and the
  // count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Zero flag.
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide functional unit. It accepts one
// operation from a reservation station, keeps it for a fixed latency,
// then holds the result on the common data bus until it is granted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 3,
  parameter int TAG_W   = 3,
  parameter int MUL_LAT = 3,   // legal range 1..15
  parameter int DIV_LAT = 4    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_x,
  input  logic [DATA_W-1:0] src_y,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [TAG_W-1:0]  tag,
  output logic              cdb_valid,
  input  logic              cdb_grant,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] result_addr,
  output logic [TAG_W-1:0]  result_tag,
  output logic              div_by_zero,
  output logic              illegal_op
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  state_t state;
  state_t next_state;

  logic              accept;
  logic              op_legal;

  logic [2:0]        op_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TAG_W-1:0]  tag_q;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_value;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic              exec_done;

  logic [DATA_W-1:0] mul_result;
  logic [DATA_W-1:0] div_result;
  logic              div_zero;
  logic [DATA_W-1:0] arith_result;
  logic              arith_dbz;

  // The counter is loaded with the full latency on accept and ticks once
  // per EXEC cycle; the last EXEC cycle is the one where it still reads 1.
  lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  // Handshake decode shared by the FSM and the capture registers.
  always_comb begin
    accept    = issue_valid && issue_ready;
    op_legal  = is_legal_op(op);
    exec_done = (state == EXEC) && ((cnt_value == CNT_W'(1)) || cnt_zero);
  end

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the handshake outputs and counter controls.
  always_comb begin
    next_state     = state;
    issue_ready    = 1'b0;
    cdb_valid      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && op_legal) begin
          next_state     = EXEC;
          cnt_load       = 1'b1;
          cnt_load_value = (op == OP_MUL) ? MUL_CNT : DIV_CNT;
        end
      end
      EXEC: begin
        cnt_dec = 1'b1;
        if (exec_done) begin
          next_state = WAIT_CDB;
        end
      end
      WAIT_CDB: begin
        cdb_valid = 1'b1;
        if (cdb_grant) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture on a legal accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      tag_q  <= '0;
    end else if (accept && op_legal) begin
      op_q   <= op;
      x_q    <= src_x;
      y_q    <= src_y;
      addr_q <= dest_addr;
      tag_q  <= tag;
    end
  end

  // Arithmetic from the captured operands. Assigning the product to a
  // DATA_W-wide target keeps only its low bits, which is the intended
  // silent truncation; division by zero yields all ones.
  always_comb begin
    mul_result = x_q * y_q;
    div_zero   = (y_q == '0);
    div_result = div_zero ? '1 : (x_q / y_q);
    if (op_q == OP_MUL) begin
      arith_result = mul_result;
      arith_dbz    = 1'b0;
    end else begin
      arith_result = div_result;
      arith_dbz    = div_zero;
    end
  end

  // Broadcast registers, loaded as the FSM enters WAIT_CDB and then held
  // steady until the bus grants them.
  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      result_addr <= '0;
      result_tag  <= '0;
      div_by_zero <= 1'b0;
    end else if (exec_done) begin
      result      <= arith_result;
      result_addr <= addr_q;
      result_tag  <= tag_q;
      div_by_zero <= arith_dbz;
    end
  end

  // Illegal opcodes are consumed in IDLE and flagged for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && !op_legal;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios followed by
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int DATA_W  = 9;
  localparam int ADDR_W  = 3;
  localparam int TAG_W   = 3;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 4;

  localparam logic [2:0] MUL_CODE = 3'b010;
  localparam logic [2:0] DIV_CODE = 3'b011;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_x;
  logic [DATA_W-1:0] src_y;
  logic [ADDR_W-1:0] dest_addr;
  logic [TAG_W-1:0]  tag;
  logic              cdb_valid;
  logic              cdb_grant;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] result_addr;
  logic [TAG_W-1:0]  result_tag;
  logic              div_by_zero;
  logic              illegal_op;

  int vectors     = 0;
  int miscompares = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  muldiv_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TAG_W   (TAG_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op          (op),
    .src_x       (src_x),
    .src_y       (src_y),
    .dest_addr   (dest_addr),
    .tag         (tag),
    .cdb_valid   (cdb_valid),
    .cdb_grant   (cdb_grant),
    .result      (result),
    .result_addr (result_addr),
    .result_tag  (result_tag),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  // Reference result straight from the arithmetic definition.
  function automatic int refResult(input logic [2:0] code, input int x, input int y);
    if (code == MUL_CODE) return (x * y) % (1 << DATA_W);
    if (y == 0) return (1 << DATA_W) - 1;
    return x / y;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  // Presents one issue from a negedge, lets the next rising edge accept
  // it, then scrambles the inputs so a late capture would show up.
  task automatic applyStimulus(input logic [2:0] code, input int x, input int y,
                               input int addr, input int tg);
    issue_valid = 1'b1;
    op          = code;
    src_x       = DATA_W'(x);
    src_y       = DATA_W'(y);
    dest_addr   = ADDR_W'(addr);
    tag         = TAG_W'(tg);
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b0;
    op          = 3'($urandom);
    src_x       = DATA_W'($urandom);
    src_y       = DATA_W'($urandom);
    dest_addr   = ADDR_W'($urandom);
    tag         = TAG_W'($urandom);
  endtask

  // Full legal operation: latency, broadcast contents, hold while the
  // grant is withheld, then release back to IDLE.
  task automatic runOp(input logic [2:0] code, input int x, input int y,
                       input int addr, input int tg, input int hold,
                       input logic grant_high);
    int k;
    int exp_lat;
    int exp_res;
    logic exp_dbz;
    exp_lat   = (code == MUL_CODE) ? MUL_LAT : DIV_LAT;
    exp_res   = refResult(code, x, y);
    exp_dbz   = (code == DIV_CODE) && (y == 0);
    cdb_grant = grant_high;
    applyStimulus(code, x, y, addr, tg);
    checkOutput("exec_ready", issue_ready, 0);
    k = 0;
    while (!cdb_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency", k, exp_lat);
    checkOutput("result", result, exp_res);
    checkOutput("result_addr", result_addr, addr);
    checkOutput("result_tag", result_tag, tg);
    checkOutput("div_by_zero", div_by_zero, exp_dbz);
    checkOutput("wait_ready", issue_ready, 0);
    if (!grant_high) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("hold_valid", cdb_valid, 1);
        checkOutput("hold_result", result, exp_res);
        checkOutput("hold_ready", issue_ready, 0);
      end
      cdb_grant = 1'b1;
    end
    @(negedge clk);
    checkOutput("release_valid", cdb_valid, 0);
    checkOutput("release_ready", issue_ready, 1);
    cdb_grant = 1'b0;
  endtask

  initial begin
    logic [2:0] code;
    int x;
    int y;
    int cycles_valid;

    reset       = 1'b1;
    issue_valid = 1'b0;
    op          = '0;
    src_x       = '0;
    src_y       = '0;
    dest_addr   = '0;
    tag         = '0;
    cdb_grant   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_ready", issue_ready, 1);
    checkOutput("rst_valid", cdb_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_addr", result_addr, 0);
    checkOutput("rst_tag", result_tag, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    checkOutput("rst_illegal", illegal_op, 0);

    $display("[TB] directed operations");
    runOp(MUL_CODE, 12, 5, 4, 2, 0, 1'b1);
    runOp(DIV_CODE, 200, 7, 1, 5, 0, 1'b0);
    runOp(MUL_CODE, 30, 20, 6, 3, 0, 1'b0);
    runOp(DIV_CODE, 45, 0, 7, 1, 0, 1'b0);
    runOp(MUL_CODE, 3, 3, 2, 6, 5, 1'b0);
    runOp(MUL_CODE, 511, 511, 3, 7, 1, 1'b0);

    $display("[TB] reset during execute");
    applyStimulus(DIV_CODE, 100, 3, 5, 4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready", issue_ready, 1);
    checkOutput("abort_result", result, 0);
    cycles_valid = 0;
    repeat (8) begin
      if (cdb_valid) cycles_valid++;
      @(negedge clk);
    end
    checkOutput("abort_no_broadcast", cycles_valid, 0);

    $display("[TB] illegal opcode");
    applyStimulus(3'b111, 9, 9, 1, 1);
    checkOutput("illegal_pulse", illegal_op, 1);
    checkOutput("illegal_ready", issue_ready, 1);
    @(negedge clk);
    checkOutput("illegal_drop", illegal_op, 0);
    cycles_valid = 0;
    repeat (6) begin
      if (cdb_valid) cycles_valid++;
      @(negedge clk);
    end
    checkOutput("illegal_no_broadcast", cycles_valid, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        code = 3'($urandom_range(0, 5));
        if (code >= 3'd2) code = code + 3'd2;
        applyStimulus(code, $urandom_range(0, 511), $urandom_range(0, 511), 0, 0);
        checkOutput("rand_illegal_pulse", illegal_op, 1);
        @(negedge clk);
        checkOutput("rand_illegal_drop", illegal_op, 0);
        checkOutput("rand_illegal_valid", cdb_valid, 0);
      end else begin
        code = ($urandom_range(0, 1) == 0) ? MUL_CODE : DIV_CODE;
        x    = $urandom_range(0, (1 << DATA_W) - 1);
        y    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << DATA_W) - 1);
        runOp(code, x, y, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
